fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the LEGv8 single-cycle datapath. It owns the program counter, requests instruction words from code memory over a req/ack handshake, and holds each fetched word for the datapath with a valid/ready handshake. When the datapath consumes a word, the unit resolves B (and optionally CBZ) next-PC locally.

---
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage in front of the LEGv8 single-cycle
//            datapath. It owns the PC, fetches words from code memory over a
//            req/ack handshake with a timeout-and-retry, and presents each
//            word to the datapath over a valid/ready handshake. It resolves
//            B (and optionally CBZ) next-PC when the word is consumed.
// Ports    : iCLK, iReset          - clock, synchronous active-high reset
//            oMemReq/oMemAddr      - code memory request and byte address
//            iMemAck/iMemData      - code memory response
//            oValid/iReady         - datapath handshake
//            oInstruction/oPC      - held instruction word and its address
//            iZero                 - ALU zero flag (CBZ only)
//            oRetry                - one-cycle pulse on request timeout
// Config   : define FETCH_CBZ_EN to decode CBZ as a conditional branch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                  PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  MEM_TIMEOUT = 15
) (
  input  logic                iCLK,
  input  logic                iReset,
  output logic                oMemReq,
  output logic [PC_WIDTH-1:0] oMemAddr,
  input  logic                iMemAck,
  input  logic [31:0]         iMemData,
  output logic                oValid,
  input  logic                iReady,
  output logic [31:0]         oInstruction,
  output logic [PC_WIDTH-1:0] oPC,
  input  logic                iZero,
  output logic                oRetry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Counter value seen on the last unacked REQ cycle before giving up.
  localparam logic [7:0]          TMO_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;        // address being fetched
  logic [PC_WIDTH-1:0]   opc_q, opc_d;      // address of held instruction
  logic [31:0]           instr_q, instr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  retry_q, retry_d;

  // --------------------------------------------------------------------------
  // Next-PC resolution for the held instruction
  // --------------------------------------------------------------------------
  logic                  is_b;
  logic                  cbz_taken;
  logic [PC_WIDTH-1:0]   b_off;
  logic [PC_WIDTH-1:0]   cbz_off;
  logic [PC_WIDTH-1:0]   next_pc;

  assign is_b    = (instr_q[31:26] == 6'b000101);
  assign b_off   = {{(PC_WIDTH-28){instr_q[25]}}, instr_q[25:0], 2'b00};
  assign cbz_off = {{(PC_WIDTH-21){instr_q[23]}}, instr_q[23:5], 2'b00};

`ifdef FETCH_CBZ_EN
  assign cbz_taken = (instr_q[31:24] == 8'b10110100) && iZero;
`else
  // CBZ falls through sequentially; the zero flag has no consumer.
  logic unused_zero;
  assign unused_zero = iZero;
  assign cbz_taken   = 1'b0;
`endif

  // Additions wrap modulo 2^PC_WIDTH by construction.
  assign next_pc = is_b      ? (opc_q + b_off)   :
                   cbz_taken ? (opc_q + cbz_off) :
                               (opc_q + PC_STEP);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (iReset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      opc_q   <= RESET_PC;
      instr_q <= 32'h0;
      cnt_q   <= 8'h0;
      retry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opc_d   = opc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    retry_d = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // An ack on the timeout cycle takes priority over the retry.
        if (iMemAck) begin
          instr_d = iMemData;
          opc_d   = pc_q;
          cnt_d   = 8'h0;
          state_d = HOLD;
        end else if (cnt_q == TMO_LAST) begin
          retry_d = 1'b1;
          cnt_d   = 8'h0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      GAP: state_d = REQ;
      HOLD: begin
        if (iReady) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come from registers or state decode only.
  assign oMemReq      = (state_q == REQ);
  assign oMemAddr     = pc_q;
  assign oValid       = (state_q == HOLD);
  assign oInstruction = instr_q;
  assign oPC          = opc_q;
  assign oRetry       = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. Expected {PC, word} pairs
//            are queued when an ack is driven and popped when oValid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        iReset;
  logic        oMemReq;
  logic [63:0] oMemAddr;
  logic        iMemAck;
  logic [31:0] iMemData;
  logic        oValid;
  logic        iReady;
  logic [31:0] oInstruction;
  logic [63:0] oPC;
  logic        iZero;
  logic        oRetry;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  logic [63:0] exp_pc;

  localparam logic [31:0] ADD = 32'h8B020020;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_WIDTH    (64),
    .RESET_PC    (64'h0),
    .MEM_TIMEOUT (15)
  ) dut (
    .iCLK         (clk),
    .iReset       (iReset),
    .oMemReq      (oMemReq),
    .oMemAddr     (oMemAddr),
    .iMemAck      (iMemAck),
    .iMemData     (iMemData),
    .oValid       (oValid),
    .iReady       (iReady),
    .oInstruction (oInstruction),
    .oPC          (oPC),
    .iZero        (iZero),
    .oRetry       (oRetry)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC: signed offsets in word units, scaled to bytes.
  function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [31:0] ins,
                                             input logic z);
    logic signed [25:0] i26;
    logic signed [18:0] i19;
    i26 = ins[25:0];
    i19 = ins[23:5];
    if (ins[31:26] == 6'b000101) return pc + 64'(longint'(i26) * 4);
`ifdef FETCH_CBZ_EN
    if (ins[31:24] == 8'hB4 && z) return pc + 64'(longint'(i19) * 4);
`else
    if (z && i19 == 19'sd0) return pc + 64'd4;
`endif
    return pc + 64'd4;
  endfunction

  function automatic logic [31:0] b_to(input logic [63:0] from, input logic [63:0] to);
    logic [63:0] d;
    d = (to - from) >> 2;
    return {6'b000101, d[25:0]};
  endfunction

  // One full fetch: ack after ack_dly unacked REQ cycles, then consume after
  // hold_dly cycles of iReady=0.
  task automatic fetch_one(input logic [31:0] data, input int ack_dly, input int hold_dly,
                           input logic z);
    exp_t e;
    check("req_on", 64'(oMemReq), 64'd1);
    check("req_addr", oMemAddr, exp_pc);
    for (int k = 0; k < ack_dly; k++) begin
      iMemAck = 1'b0;
      step();
      check("req_wait", 64'(oMemReq), 64'd1);
      check("addr_stable", oMemAddr, exp_pc);
      check("no_retry_wait", 64'(oRetry), 64'd0);
    end
    iMemAck  = 1'b1;
    iMemData = data;
    sb.push_back('{pc: exp_pc, ins: data});
    step();
    iMemAck  = 1'b0;
    iMemData = $urandom;
    check("valid_on", 64'(oValid), 64'd1);
    check("no_retry_ack", 64'(oRetry), 64'd0);
    check("req_off_hold", 64'(oMemReq), 64'd0);
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("hold_pc", oPC, e.pc);
      check("hold_ins", 64'(oInstruction), 64'(e.ins));
    end
    for (int k = 0; k < hold_dly; k++) begin
      iReady = 1'b0;
      iZero  = 1'($urandom);
      step();
      check("hold_valid", 64'(oValid), 64'd1);
      check("hold_pc_stable", oPC, e.pc);
      check("hold_ins_stable", 64'(oInstruction), 64'(e.ins));
      check("hold_noreq", 64'(oMemReq), 64'd0);
    end
    iReady = 1'b1;
    iZero  = z;
    step();
    iReady = 1'b0;
    iZero  = 1'b0;
    exp_pc = model_next(e.pc, e.ins, z);
    check("after_valid", 64'(oValid), 64'd0);
  endtask

  initial begin
    iReset   = 1'b1;
    iMemAck  = 1'b0;
    iMemData = 32'h0;
    iReady   = 1'b0;
    iZero    = 1'b0;
    repeat (3) step();
    check("rst_req", 64'(oMemReq), 64'd0);
    check("rst_addr", oMemAddr, 64'h0);
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_ins", 64'(oInstruction), 64'd0);
    check("rst_pc", oPC, 64'h0);
    check("rst_retry", 64'(oRetry), 64'd0);

    // One IDLE cycle after reset release, then REQ.
    iReset = 1'b0;
    check("idle_noreq", 64'(oMemReq), 64'd0);
    step();
    exp_pc = 64'h0;

    // Back-to-back fetches at 0,4,8, one word every two cycles.
    for (int i = 0; i < 3; i++) fetch_one(ADD, 0, 0, 1'b0);
    check("seq_pc", exp_pc, 64'hC);
    fetch_one(ADD, 0, 5, 1'b1);                      // long hold at 0xC
    fetch_one(32'h17FFFFFE, 0, 0, 1'b0);             // B -2 at 0x10 -> 0x8
    check("b_back", oMemAddr, 64'h8);
    fetch_one(32'h17FFFFFE, 1, 0, 1'b0);             // B -2 at 0x8 -> 0x0
    fetch_one(32'h17FFFFFF, 0, 0, 1'b0);             // B -1 at 0x0 -> wrap
    check("b_wrap", oMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_one(ADD, 0, 0, 1'b0);                      // 0x..FC + 4 wraps to 0
    check("pc_wrap", oMemAddr, 64'h0);
    fetch_one(b_to(exp_pc, 64'h20), 0, 0, 1'b0);
    fetch_one(32'hB4000060, 0, 1, 1'b1);             // CBZ imm19=3, zero=1
`ifdef FETCH_CBZ_EN
    check("cbz_taken", oMemAddr, 64'h2C);
`else
    check("cbz_seq", oMemAddr, 64'h24);
`endif
    fetch_one(b_to(exp_pc, 64'h20), 2, 0, 1'b0);
    fetch_one(32'hB4000060, 0, 0, 1'b0);             // CBZ, zero=0
    check("cbz_nottaken", oMemAddr, 64'h24);

    // Timeout: 15 unacked REQ cycles, GAP with retry pulse, then reissue.
    for (int k = 0; k < 15; k++) begin
      check("tmo_req", 64'(oMemReq), 64'd1);
      check("tmo_noretry", 64'(oRetry), 64'd0);
      step();
    end
    check("gap_retry", 64'(oRetry), 64'd1);
    check("gap_noreq", 64'(oMemReq), 64'd0);
    check("gap_addr", oMemAddr, exp_pc);
    iMemAck = 1'b1;                                  // late ack in GAP
    step();
    iMemAck = 1'b0;
    check("reissue_req", 64'(oMemReq), 64'd1);
    check("reissue_noretry", 64'(oRetry), 64'd0);
    check("gap_ack_ignored", 64'(oValid), 64'd0);
    check("reissue_addr", oMemAddr, exp_pc);
    fetch_one(ADD, 14, 0, 1'b0);                     // ack on 15th cycle wins

    // Reset in REQ with a simultaneous ack, then a stale ack in IDLE.
    iReset  = 1'b1;
    iMemAck = 1'b1;
    step();
    iReset  = 1'b0;
    check("rr_valid", 64'(oValid), 64'd0);
    check("rr_addr", oMemAddr, 64'h0);
    check("rr_noreq", 64'(oMemReq), 64'd0);
    step();
    iMemAck = 1'b0;
    check("idle_ack_ignored", 64'(oValid), 64'd0);
    check("rr_req", 64'(oMemReq), 64'd1);
    sb.delete();
    exp_pc = 64'h0;
    fetch_one(ADD, 0, 0, 1'b0);
    check("final_addr", oMemAddr, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
